ula_serial_seq: RTL and testbench

ULA_SERIAL_SEQ -- requirements
Module: ula_serial_seq

---
 rtl/ula_serial_seq_pkg.sv | 32 +++
 rtl/ula_serial_seq_ctl_decode.sv | 27 ++
 rtl/ula_serial_seq.sv | 173 +++++++++++++++++
 tb/tb_ula_serial_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_serial_seq_pkg.sv
// ============================================================================
// ula_serial_seq_pkg
// Shared FSM state encoding and ALU control codes for the bit-serial ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ula_serial_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // alu_ctl = {ainvert, binvert, op[1:0]}
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ula_serial_seq_ctl_decode.sv
// ============================================================================
// ula_ctl_decode
// Splits the 4-bit ALU control word into slice controls and operation class.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ula_ctl_decode
    import ula_serial_seq_pkg::*;
(
    input  logic [3:0] alu_ctl_i,
    output logic       ainvert_o,
    output logic       binvert_o,
    output logic [1:0] op_o,
    output logic       is_slt_o,
    output logic       is_arith_o
);

    assign ainvert_o  = alu_ctl_i[3];
    assign binvert_o  = alu_ctl_i[2];
    assign op_o       = alu_ctl_i[1:0];
    assign is_slt_o   = (alu_ctl_i[1:0] == OP_LESS);
    assign is_arith_o = (alu_ctl_i[1:0] == OP_SUM);

endmodule

`default_nettype wire

// File: rtl/ula_serial_seq.sv
// ============================================================================
// ula_serial_seq
// Bit-serial WIDTH-bit ALU sequencer driving one external 1-bit ALU slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ula_serial_seq
    import ula_serial_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_less,
    output logic             slice_cin,
    output logic             slice_ainvert,
    output logic             slice_binvert,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set,
    input  logic             slice_overflow
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         ctl_q, ctl_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               set_q, set_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;

    logic               w_ainvert;
    logic               w_binvert;
    logic [1:0]         w_op;
    logic               w_is_slt;
    logic               w_is_arith;
    logic               w_run;
    logic [WIDTH-1:0]   w_slt_word;
    logic [WIDTH-1:0]   w_final;

    ula_ctl_decode u_decode (
        .alu_ctl_i  (ctl_q),
        .ainvert_o  (w_ainvert),
        .binvert_o  (w_binvert),
        .op_o       (w_op),
        .is_slt_o   (w_is_slt),
        .is_arith_o (w_is_arith)
    );

    always_comb begin
        w_slt_word    = '0;
        w_slt_word[0] = set_q;
    end

    // SLT replaces the serially built word with the sign of a-b.
    assign w_final = w_is_slt ? w_slt_word : result_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        ctl_d      = ctl_q;
        result_d   = result_q;
        set_d      = set_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    ctl_d    = alu_ctl;
                    result_d = '0;
                    cnt_d    = '0;
                    // binvert doubles as the +1 of two's-complement subtract
                    carry_d  = alu_ctl[2];
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[cnt_q] = slice_result;
                carry_d         = slice_cout;
                cnt_d           = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    set_d   = slice_set;
                    ovf_d   = slice_overflow;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                result_d   = w_final;
                overflow_d = w_is_arith & ovf_q;
                zero_d     = (w_final == '0);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ctl_q      <= '0;
            result_q   <= '0;
            set_q      <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctl_q      <= ctl_d;
            result_q   <= result_d;
            set_q      <= set_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign w_run    = (state_q == ST_RUN);
    assign busy     = w_run || (state_q == ST_FIN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

    assign slice_a       = w_run & a_q[cnt_q];
    assign slice_b       = w_run & b_q[cnt_q];
    assign slice_cin     = w_run & carry_q;
    assign slice_less    = 1'b0;
    assign slice_ainvert = w_run & w_ainvert;
    assign slice_binvert = w_run & w_binvert;
    assign slice_op      = w_run ? w_op : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_ula_serial_seq.sv
// ============================================================================
// tb_ula_serial_seq
// Directed bench for ula_serial_seq with a behavioural 1-bit ALU slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ula_serial_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             slice_a, slice_b, slice_less, slice_cin;
    logic             slice_ainvert, slice_binvert;
    logic [1:0]       slice_op;
    logic             slice_result, slice_cout, slice_set, slice_overflow;

    int n_checks;
    int n_pass;

    always #5 clk = ~clk;

    ula_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .alu_ctl        (alu_ctl),
        .a              (a),
        .b              (b),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .zero           (zero),
        .overflow       (overflow),
        .slice_a        (slice_a),
        .slice_b        (slice_b),
        .slice_less     (slice_less),
        .slice_cin      (slice_cin),
        .slice_ainvert  (slice_ainvert),
        .slice_binvert  (slice_binvert),
        .slice_op       (slice_op),
        .slice_result   (slice_result),
        .slice_cout     (slice_cout),
        .slice_set      (slice_set),
        .slice_overflow (slice_overflow)
    );

    // External 1-bit ALU slice (classic MIPS style, set = raw sum bit)
    logic w_sa, w_sb, w_sum;
    always_comb begin
        w_sa           = slice_a ^ slice_ainvert;
        w_sb           = slice_b ^ slice_binvert;
        w_sum          = w_sa ^ w_sb ^ slice_cin;
        slice_cout     = (w_sa & w_sb) | (w_sa & slice_cin) | (w_sb & slice_cin);
        slice_set      = w_sum;
        slice_overflow = slice_cin ^ slice_cout;
        case (slice_op)
            2'b00:   slice_result = w_sa & w_sb;
            2'b01:   slice_result = w_sa | w_sb;
            2'b10:   slice_result = w_sum;
            default: slice_result = slice_less;
        endcase
    end

    // Waits for the DUT to be idle, issues one start, returns clocks to done.
    task automatic run_op(input logic [3:0] ctl, input logic [WIDTH-1:0] aa,
                          input logic [WIDTH-1:0] bb, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        alu_ctl = ctl;
        a       = aa;
        b       = bb;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        start   = 1'b1;
        alu_ctl = 4'b0010;
        a       = 32'h1;
        b       = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else n_pass++;
        n_checks++; if ({zero, overflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {zero, overflow}); else n_pass++;
        n_checks++;
        if ({slice_a, slice_b, slice_cin, slice_less, slice_ainvert, slice_binvert, slice_op} !== 8'h00)
            $display("FAIL reset_slice: got %h expected 00",
                     {slice_a, slice_b, slice_cin, slice_less, slice_ainvert, slice_binvert, slice_op});
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_add;
        int lat;
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        n_checks++; if (lat !== 33) $display("FAIL add_latency: got %0d expected 33", lat); else n_pass++;
        n_checks++; if (result !== 32'h8000_0000) $display("FAIL add_result: got %h expected 80000000", result); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL add_overflow: got %b expected 1", overflow); else n_pass++;
        n_checks++; if (zero !== 1'b0) $display("FAIL add_zero: got %b expected 0", zero); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) $display("FAIL add_done_width: got %b expected 0", done); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({result, overflow, zero} !== {32'h8000_0000, 1'b1, 1'b0})
            $display("FAIL add_hold: got %h %b %b expected 80000000 1 0", result, overflow, zero);
        else n_pass++;
        n_checks++;
        if ({slice_a, slice_b, slice_cin, slice_binvert, slice_op} !== 6'b0)
            $display("FAIL idle_slice: got %b expected 000000", {slice_a, slice_b, slice_cin, slice_binvert, slice_op});
        else n_pass++;
    endtask

    task automatic test_sub;
        int lat;
        @(negedge clk);
        alu_ctl = 4'b0110;
        a       = 32'h0000_0005;
        b       = 32'h0000_0005;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({busy, slice_cin, slice_binvert, slice_ainvert, slice_op, slice_a, slice_b} !== 8'b1110_1011)
            $display("FAIL sub_first_bit: got %b expected 11101011",
                     {busy, slice_cin, slice_binvert, slice_ainvert, slice_op, slice_a, slice_b});
        else n_pass++;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++; if (lat !== 33) $display("FAIL sub_latency: got %0d expected 33", lat); else n_pass++;
        n_checks++;
        if ({result, zero, overflow} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL sub_equal: got %h z=%b v=%b expected 00000000 z=1 v=0", result, zero, overflow);
        else n_pass++;
        run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, lat);
        n_checks++;
        if ({result, zero, overflow} !== {32'h7FFF_FFFF, 1'b0, 1'b1})
            $display("FAIL sub_overflow: got %h z=%b v=%b expected 7fffffff z=0 v=1", result, zero, overflow);
        else n_pass++;
    endtask

    task automatic test_slt;
        int lat;
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        n_checks++;
        if ({result, zero, overflow} !== {32'h0000_0001, 1'b0, 1'b0})
            $display("FAIL slt_less: got %h z=%b v=%b expected 00000001 z=0 v=0", result, zero, overflow);
        else n_pass++;
        run_op(4'b0111, 32'h0000_0007, 32'h0000_0003, lat);
        n_checks++;
        if ({result, zero} !== {32'h0, 1'b1})
            $display("FAIL slt_not_less: got %h z=%b expected 00000000 z=1", result, zero);
        else n_pass++;
    endtask

    task automatic test_logic;
        int lat;
        run_op(4'b1100, 32'h0, 32'h0, lat);
        n_checks++;
        if ({result, overflow, zero} !== {32'hFFFF_FFFF, 1'b0, 1'b0})
            $display("FAIL nor: got %h v=%b z=%b expected ffffffff v=0 z=0", result, overflow, zero);
        else n_pass++;
        run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        n_checks++;
        if ({result, overflow} !== {32'hF000_F000, 1'b0})
            $display("FAIL and: got %h v=%b expected f000f000 v=0", result, overflow);
        else n_pass++;
        run_op(4'b1101, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        n_checks++;
        if (result !== 32'h0FFF_0FFF) $display("FAIL nand_decode: got %h expected 0fff0fff", result); else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int          pulses;
        int          done_at;
        logic [31:0] r_at;
        pulses  = 0;
        done_at = -1;
        r_at    = '0;
        @(negedge clk);
        while ((busy || done) && pulses < 100) begin
            @(negedge clk);
            pulses++;
        end
        pulses  = 0;
        alu_ctl = 4'b0010;
        a       = 32'd3;
        b       = 32'd4;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        alu_ctl = 4'b0000;
        a       = 32'd100;
        b       = 32'd200;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                done_at = i;
                r_at    = result;
            end
        end
        n_checks++; if (pulses !== 1) $display("FAIL ignore_pulses: got %0d expected 1", pulses); else n_pass++;
        n_checks++; if (done_at !== 26) $display("FAIL ignore_no_restart: got %0d expected 26", done_at); else n_pass++;
        n_checks++; if (r_at !== 32'd7) $display("FAIL ignore_result: got %h expected 00000007", r_at); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        int lat;
        pulses = 0;
        @(negedge clk);
        alu_ctl = 4'b0010;
        a       = 32'hFFFF_FFFF;
        b       = 32'hFFFF_FFFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, zero, overflow, slice_a} !== 5'b0 || result !== 32'h0)
            $display("FAIL midrun_reset: got busy=%b done=%b result=%h expected busy=0 done=0 result=00000000",
                     busy, done, result);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL midrun_no_done: got %0d expected 0", pulses); else n_pass++;
        run_op(4'b0001, 32'h1234_0000, 32'h0000_5678, lat);
        n_checks++;
        if (lat !== 33 || result !== 32'h1234_5678)
            $display("FAIL midrun_recover: got lat=%0d result=%h expected lat=33 result=12345678", lat, result);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(4'b0010, 32'h1234_5678, 32'h1111_1111, lat);
        n_checks++; if (result !== 32'h2345_6789) $display("FAIL b2b_add: got %h expected 23456789", result); else n_pass++;
        run_op(4'b0110, 32'd10, 32'd3, lat);
        n_checks++;
        if (lat !== 33 || result !== 32'd7)
            $display("FAIL b2b_sub: got lat=%0d result=%h expected lat=33 result=00000007", lat, result);
        else n_pass++;
        run_op(4'b0010, 32'h8000_0000, 32'h8000_0000, lat);
        n_checks++;
        if ({result, zero, overflow} !== {32'h0, 1'b1, 1'b1})
            $display("FAIL b2b_wrap: got %h z=%b v=%b expected 00000000 z=1 v=1", result, zero, overflow);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        alu_ctl  = 4'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
